// File: rtl/cnn_pkg.sv
// cnn_pkg: shared sizes and FSM encoding for the line buffer and window/MAC stages.
package cnn_pkg;
    localparam int PIX_W  = 8;
    localparam int ROW_W  = 28;
    localparam int IMG_H  = 28;
    localparam int ADDR_W = 10;
    localparam int COL_W  = $clog2(ROW_W);
    localparam int ROWS_W = $clog2(IMG_H + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } lb_state_e;
endpackage

// File: rtl/line_buffer_fill_if.sv
// line_buffer_fill_if: pixel stream, window read and row handshake bundle of the line buffer.
interface line_buffer_fill_if;
    import cnn_pkg::*;
    logic                 frame_start;
    logic [PIX_W-1:0]     pix_in;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [3*PIX_W-1:0]   LB1;
    logic [3*PIX_W-1:0]   LB2;
    logic [3*PIX_W-1:0]   LB3;
    logic                 data_valid;
    logic                 row_done;
    logic [1:0]           wr_sel;
    logic                 frame_done;

    modport slave (
        input  frame_start, pix_in, pix_valid, rd_en, rd_addr, row_done,
        output pix_ready, LB1, LB2, LB3, data_valid, wr_sel, frame_done
    );
    modport master (
        output frame_start, pix_in, pix_valid, rd_en, rd_addr, row_done,
        input  pix_ready, LB1, LB2, LB3, data_valid, wr_sel, frame_done
    );
endinterface

// File: rtl/lb_row_ram.sv
// lb_row_ram: one image row of storage, single write port, registered 3-pixel read port.
// Macro LB_ZERO_PAD_EN: columns past the row end read as 0; otherwise they replicate the last pixel.
module lb_row_ram import cnn_pkg::*; (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_we,
    input  logic [COL_W-1:0]    i_waddr,
    input  logic [PIX_W-1:0]    i_wdata,
    input  logic                i_re,
    input  logic [ADDR_W-1:0]   i_raddr,
    output logic [3*PIX_W-1:0]  o_rdata
);
    logic [PIX_W-1:0]   r_mem [ROW_W];
    logic [3*PIX_W-1:0] w_slice;

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    for (genvar k = 0; k < 3; k++) begin : g_slot
        logic [ADDR_W:0]  w_col;
        logic             w_oob;
        logic [COL_W-1:0] w_idx;
        assign w_col = {1'b0, i_raddr} + (ADDR_W+1)'(k);
        assign w_oob = w_col >= (ADDR_W+1)'(ROW_W);
        assign w_idx = w_oob ? COL_W'(ROW_W-1) : w_col[COL_W-1:0];
`ifdef LB_ZERO_PAD_EN
        assign w_slice[k*PIX_W +: PIX_W] = w_oob ? '0 : r_mem[w_idx];
`else
        assign w_slice[k*PIX_W +: PIX_W] = r_mem[w_idx];
`endif
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) o_rdata <= '0;
        else if (i_re) o_rdata <= w_slice;
endmodule

// File: rtl/line_buffer_fill.sv
// line_buffer_fill: fills three rotating row buffers from a raster stream and serves 3x3 window slices.
// Edge handling of reads past the row end selected by macro LB_ZERO_PAD_EN (see lb_row_ram).
module line_buffer_fill import cnn_pkg::*; (
    input  logic               clk,
    input  logic               rst,
    line_buffer_fill_if.slave  bus
);
    lb_state_e           r_state, w_state_nx;
    logic [COL_W-1:0]    r_col, w_col_nx;
    logic [1:0]          r_res, w_res_nx;
    logic [1:0]          r_wr_sel, w_sel_nx;
    logic [ROWS_W-1:0]   r_rows, w_rows_nx;
    logic                r_fd, w_fd_nx;
    logic                w_acc, w_eol;
    logic [3*PIX_W-1:0]  w_lb [3];

    assign w_acc = r_state == FILL && bus.pix_valid && !bus.frame_start;
    assign w_eol = r_col == COL_W'(ROW_W-1);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state  <= IDLE;
            r_col    <= '0;
            r_res    <= '0;
            r_wr_sel <= '0;
            r_rows   <= '0;
            r_fd     <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_col    <= w_col_nx;
            r_res    <= w_res_nx;
            r_wr_sel <= w_sel_nx;
            r_rows   <= w_rows_nx;
            r_fd     <= w_fd_nx;
        end

    // A released row keeps wr_sel: the oldest buffer is the one about to be refilled.
    always_comb begin
        w_state_nx = r_state;
        w_col_nx   = r_col;
        w_res_nx   = r_res;
        w_sel_nx   = r_wr_sel;
        w_rows_nx  = r_rows;
        w_fd_nx    = 1'b0;
        if (bus.frame_start) begin
            w_state_nx = FILL;
            w_col_nx   = '0;
            w_res_nx   = '0;
            w_sel_nx   = '0;
            w_rows_nx  = '0;
        end else begin
            case (r_state)
                FILL: if (w_acc) begin
                    w_col_nx = w_eol ? '0 : r_col + 1'b1;
                    if (w_eol) begin
                        w_res_nx   = r_res + 1'b1;
                        w_rows_nx  = r_rows + 1'b1;
                        w_sel_nx   = r_wr_sel == 2'd2 ? 2'd0 : r_wr_sel + 1'b1;
                        w_state_nx = r_res == 2'd2 ? HOLD : FILL;
                    end
                end
                HOLD: if (bus.row_done) begin
                    w_fd_nx    = r_rows == ROWS_W'(IMG_H);
                    w_state_nx = r_rows == ROWS_W'(IMG_H) ? IDLE : FILL;
                    w_res_nx   = 2'd2;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_buf
        lb_row_ram u_ram (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_acc && r_wr_sel == 2'(g)),
            .i_waddr (r_col),
            .i_wdata (bus.pix_in),
            .i_re    (bus.rd_en),
            .i_raddr (bus.rd_addr),
            .o_rdata (w_lb[g])
        );
    end

    assign bus.pix_ready  = r_state == FILL;
    assign bus.data_valid = r_state == HOLD;
    assign bus.wr_sel     = r_wr_sel;
    assign bus.frame_done = r_fd;
    assign bus.LB1        = w_lb[0];
    assign bus.LB2        = w_lb[1];
    assign bus.LB3        = w_lb[2];
endmodule

// File: doc/line_buffer_fill.md
Name: line_buffer_fill

Overview:
- Upstream stage of the 3x3 convolution window engine.
- Accepts a raster pixel stream and writes it row by row into three rotating row buffers.
- Raises data_valid once three complete rows are resident.
- Serves 3-pixel-wide reads per buffer at the consumer's rd_addr, then frees the oldest row when the consumer signals it has finished with it.

Parameters:
- PIX_W, 8: pixel width in bits.
- ROW_W, 28: pixels per image row.
- IMG_H, 28: rows per frame.
- ADDR_W, 10: width of rd_addr.

Ports:
- clk  in  1: system clock, rising edge.
- rst  in  1: asynchronous, active-low reset.
- frame_start  in  1: single-cycle pulse; clears all state and begins a new frame.
- pix_in  in  PIX_W: incoming pixel.
- pix_valid  in  1: pix_in is valid.
- pix_ready  out  1: pixel accepted when pix_valid and pix_ready are both high.
- rd_en  in  1: read request from the consumer.
- rd_addr  in  ADDR_W: column index of the leftmost pixel to read.
- LB1  out  3*PIX_W: window slice from buffer 0.
- LB2  out  3*PIX_W: window slice from buffer 1.
- LB3  out  3*PIX_W: window slice from buffer 2.
- data_valid  out  1: level signal; three complete rows are resident.
- row_done  in  1: single-cycle pulse; consumer has finished the current window row.
- wr_sel  out  2: index (0..2) of the buffer currently being filled.
- frame_done  out  1: single-cycle pulse after the final window row is released.

Behaviour:
- Reset (rst low, asynchronous) forces:
  - state=IDLE; pix_ready=0, data_valid=0, frame_done=0, wr_sel=0.
  - LB1/LB2/LB3=0; column counter, rows_resident and rows_written all 0.
- Buffer storage contents are not reset.
- States:
  - IDLE: pix_ready=0. On frame_start go to FILL with wr_sel=0 and all counters 0.
  - FILL: pix_ready=1, data_valid=0.
    - Each accepted pixel is written to buf[wr_sel][col]; col increments.
    - At col==ROW_W-1: col wraps to 0, rows_resident++, rows_written++, wr_sel advances 0->1->2->0.
    - If rows_resident reaches 3, go to HOLD.
  - HOLD: pix_ready=0, data_valid=1.
    - On row_done with rows_written==IMG_H: pulse frame_done for 1 cycle, data_valid=0, go to IDLE.
    - On row_done otherwise: rows_resident=2, go to FILL. The next row overwrites the oldest buffer, which is the current wr_sel.
- frame_start in any state overrides everything else that cycle and re-enters FILL cleared.
- row_done outside HOLD is ignored.
- Reads:
  - Served in any state; latency is 1 cycle.
  - rd_en sampled at cycle t gives, at t+1, LBn = {buf[n][a+2], buf[n][a+1], buf[n][a]}, with buf[n][a] in bits [PIX_W-1:0] and a=rd_addr.
  - When rd_en is low, LBn holds its previous value.
- Simultaneous write and read of the same buffer cannot occur, because reads are only meaningful in HOLD.
- Columns >= ROW_W are handled per the optional feature.
- Rotation of the LBn outputs into the top/middle/bottom rows of the window is the consumer's job; this block always drives physical buffer n on LB(n+1).

Optional Feature:
- Macro: LB_ZERO_PAD_EN.
- Defined: any column index >= ROW_W returns 0 for that pixel slot (zero padding at the right edge).
- Undefined: the column index is clamped to ROW_W-1 (edge replication).

Decomposition:
- Shared package cnn_pkg holds PIX_W, ROW_W, IMG_H, ADDR_W defaults and the 2-bit state encoding (IDLE/FILL/HOLD), so they can be reused by the window/MAC stage.
- One natural sub-module, lb_row_ram: a single row buffer with one write port and a 3-wide registered read port, instantiated three times.

Test Plan:
- Reset mid-FILL after 40 pixels, then release rst -> all outputs at reset values; IDLE until frame_start; data_valid stays 0.
- frame_start, then 84 pixels with values 0..83 and no stalls -> data_valid rises the cycle after pixel 83 is accepted; pix_ready=0; wr_sel=0.
- In HOLD, rd_en with rd_addr=5 -> next cycle LB1=={7,6,5}, LB2=={35,34,33}, LB3=={63,62,61} (byte order MSB..LSB).
- row_done pulse, then 28 more pixels 100..127 -> data_valid drops for the refill and is written into buffer 0; then LB1 at rd_addr=0 returns {102,101,100}.
- rd_addr=27 with LB_ZERO_PAD_EN defined -> LB1=={0,0,p27}; undefined -> {p27,p27,p27}.
- Full 28-row frame, with row_done after each HOLD -> exactly 26 HOLD entries; a 1-cycle frame_done after the 26th row_done; return to IDLE.
